// File: rtl/isa_pkg.sv
// Shared ISA definitions for the execute, decode and memory-access stages.
// Holds opcode field layout, memory/compare opcodes, the bubble encoding and
// the state encoding of the memory handshake controller.
package isa_pkg;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;

    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h8;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } access_state_t;

    function automatic logic [3:0] getOpcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] getRd(input logic [INSTR_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic isMemOp(input logic [3:0] opcode);
        return (opcode == OP_LD) || (opcode == OP_ST);
    endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory handshake controller: sequences IDLE/ACCESS/DONE, owns the
// request strobe, the access timeout counter and the sticky error flag.
module mem_handshake_fsm
    import isa_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic          i_memReady,
    output access_state_t o_state,
    output logic          o_memReq,
    output logic          o_memErr,
    output logic          o_accessEnd,
    output logic          o_timeout
);

    localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);

    access_state_t r_state;
    logic [CW-1:0] r_count;
    logic          r_memReq;
    logic          r_memErr;
    logic          w_lastCycle;

    // Flag the cycle in which the access finishes, either by handshake or by giving up.
    always_comb begin
        w_lastCycle = (r_count == LP_LAST);
        o_accessEnd = (r_state == ST_ACCESS) && (i_memReady || w_lastCycle);
        o_timeout   = (r_state == ST_ACCESS) && !i_memReady && w_lastCycle;
    end

    // State, timeout counter and registered request/error outputs; a ready in the final cycle beats the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_memReq <= 1'b0;
            r_memErr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state  <= ST_ACCESS;
                        r_count  <= '0;
                        r_memReq <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_memReq <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (i_memReady) begin
                        r_state  <= ST_DONE;
                        r_memReq <= 1'b0;
                    end else if (w_lastCycle) begin
                        r_state  <= ST_DONE;
                        r_memReq <= 1'b0;
                        r_memErr <= 1'b1;
                        r_count  <= r_count + 1'b1;
                    end else begin
                        r_count  <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_memReq <= 1'b0;
                end
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_memReq = r_memReq;
    assign o_memErr = r_memErr;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through to writeback,
// performs loads/stores over a req/ready handshake and stalls upstream
// while an access is open. The writeback packet is fully registered.
module mem_access_stage
    import isa_pkg::*;
#(
    parameter int DW      = DATA_W,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   instrin,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] st_data,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   instrout,
    output logic [DW-1:0] wb_data,
    output logic [2:0]    wb_rd,
    output logic          wb_en,
    output logic          mem_err
);

    access_state_t w_state;
    logic [3:0]    w_opcode;
    logic          w_isMem;
    logic          w_accepting;
    logic          w_start;
    logic          w_accessEnd;
    logic          w_timeout;

    logic [15:0]   r_instr;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
    logic          r_memWe;

    logic [15:0]   r_instrOut;
    logic [DW-1:0] r_wbData;
    logic [2:0]    r_wbRd;
    logic          r_wbEn;

    mem_handshake_fsm #(
        .TIMEOUT (TIMEOUT),
        .CW      (4)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_start),
        .i_memReady  (mem_ready),
        .o_state     (w_state),
        .o_memReq    (mem_req),
        .o_memErr    (mem_err),
        .o_accessEnd (w_accessEnd),
        .o_timeout   (w_timeout)
    );

    // Decode the incoming instruction; stall holds upstream from the capture cycle until the access ends.
    always_comb begin
        w_opcode    = getOpcode(instrin);
        w_isMem     = isMemOp(w_opcode);
        w_accepting = (w_state != ST_ACCESS);
        w_start     = w_accepting && w_isMem;
        stall       = !reset && (w_start || ((w_state == ST_ACCESS) && !w_accessEnd));
    end

    // Capture the memory instruction and hold address/data/direction stable for the whole access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr    <= NOP;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWe    <= 1'b0;
        end else if (w_start) begin
            r_instr    <= instrin;
            r_memAddr  <= alu_result[AW-1:0];
            r_memWdata <= st_data;
            r_memWe    <= (w_opcode == OP_ST);
        end else if (w_accessEnd) begin
            r_memWe    <= 1'b0;
        end
    end

    // Writeback packet: pass-through when accepting, completed memory op at access end, bubble otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instrOut <= NOP;
            r_wbData   <= '0;
            r_wbRd     <= '0;
            r_wbEn     <= 1'b0;
        end else if (w_accepting && !w_isMem) begin
            r_instrOut <= instrin;
            r_wbData   <= alu_result;
            r_wbRd     <= getRd(instrin);
            r_wbEn     <= (instrin != NOP) && (w_opcode != OP_CMP);
        end else if (w_accessEnd) begin
            r_instrOut <= r_instr;
            r_wbRd     <= getRd(r_instr);
            if (!w_timeout && (getOpcode(r_instr) == OP_LD)) begin
                r_wbEn   <= 1'b1;
                r_wbData <= mem_rdata;
            end else begin
                r_wbEn   <= 1'b0;
                r_wbData <= '0;
            end
        end else begin
            r_instrOut <= NOP;
            r_wbData   <= '0;
            r_wbRd     <= '0;
            r_wbEn     <= 1'b0;
        end
    end

    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign instrout  = r_instrOut;
    assign wb_data   = r_wbData;
    assign wb_rd     = r_wbRd;
    assign wb_en     = r_wbEn;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed and random
// instructions and pushes expected writeback packets and memory requests;
// a memory responder and an output monitor check the DUT independently.
module tb_mem_access_stage;
    import isa_pkg::*;

    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   instrin;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] st_data;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   instrout;
    logic [DW-1:0] wb_data;
    logic [2:0]    wb_rd;
    logic          wb_en;
    logic          mem_err;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] data;
        logic [2:0]  rd;
        logic        en;
        logic        chk;
        logic        abort;
        logic        follow;
    } pkt_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          delay;
    } req_t;

    pkt_t        expQ[$];
    req_t        reqQ[$];
    logic [15:0] refMem [logic [15:0]];
    logic [15:0] devMem [logic [15:0]];
    int          tests = 0;
    int          failed = 0;
    logic        expErr = 1'b0;
    int          cyc = 0;
    int          lastCyc = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .instrin    (instrin),
        .alu_result (alu_result),
        .st_data    (st_data),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .instrout   (instrout),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_en      (wb_en),
        .mem_err    (mem_err)
    );

    function automatic logic [15:0] initVal(input logic [15:0] a);
        return a ^ 16'hA55A;
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    function automatic logic [15:0] devRead(input logic [15:0] a);
        return devMem.exists(a) ? devMem[a] : initVal(a);
    endfunction

    task automatic reportFail(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        failed++;
        $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction: record expectations from the ISA rules, drive it, and count stall cycles.
    task automatic applyStimulus(input logic [15:0] ins, input logic [15:0] alu,
                                 input logic [15:0] sd, input int delay, input bit follow);
        pkt_t       p;
        req_t       r;
        logic [3:0] op;
        int         expStall;
        int         n;
        bit         aborted;
        op       = ins[15:12];
        p.instr  = ins;
        p.rd     = ins[11:9];
        p.follow = follow;
        p.abort  = 1'b0;
        if (op == OP_LD || op == OP_ST) begin
            aborted = (delay >= TIMEOUT);
            r.addr  = alu;
            r.we    = (op == OP_ST);
            r.wdata = sd;
            r.delay = delay;
            reqQ.push_back(r);
            p.abort = aborted;
            p.en    = (op == OP_LD) && !aborted;
            p.chk   = !aborted;
            p.data  = (op == OP_LD && !aborted) ? refRead(alu) : 16'h0;
            if (op == OP_ST && !aborted) refMem[alu] = sd;
            expStall = 1 + ((delay < TIMEOUT - 1) ? delay : TIMEOUT - 1);
        end else begin
            p.en     = (ins != 16'h0) && (op != OP_CMP);
            p.data   = alu;
            p.chk    = 1'b1;
            expStall = 0;
        end
        if (ins != 16'h0) expQ.push_back(p);
        @(posedge clk);
        #1;
        instrin    = ins;
        alu_result = alu;
        st_data    = sd;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 40) begin
                reportFail("stall_stuck", n, expStall);
                break;
            end
            @(posedge clk);
        end
        checkOutput("stall_cycles", n, expStall);
    endtask

    task automatic idleInputs();
        @(posedge clk);
        #1;
        instrin    = 16'h0;
        alu_result = 16'h0;
        st_data    = 16'h0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (expQ.size() != 0) reportFail("drain_timeout", expQ.size(), 0);
    endtask

    function automatic logic [15:0] randInstr(input int kind);
        logic [3:0]  aluOps [5];
        logic [15:0] ins;
        aluOps = '{4'h0, 4'h1, 4'h5, 4'h9, 4'hC};
        case (kind)
            0, 1, 2: ins = {OP_LD, 3'($urandom_range(0, 7)), 9'($urandom)};
            3, 4:    ins = {OP_ST, 3'($urandom_range(0, 7)), 9'($urandom)};
            5:       ins = {OP_CMP, 12'($urandom)};
            6:       ins = 16'h0;
            default: begin
                ins = {aluOps[$urandom_range(0, 4)], 12'($urandom)};
                if (ins == 16'h0) ins = 16'h0001;
            end
        endcase
        return ins;
    endfunction

    // Memory responder: checks each request against the issued op and answers after the chosen delay.
    initial begin
        req_t cur;
        bit   active;
        bit   expectDrop;
        int   reqCycles;
        mem_ready  = 1'b0;
        mem_rdata  = 16'h0;
        active     = 1'b0;
        expectDrop = 1'b0;
        reqCycles  = 0;
        cur.addr   = 16'h0;
        cur.we     = 1'b0;
        cur.wdata  = 16'h0;
        cur.delay  = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (reset) begin
                active     = 1'b0;
                expectDrop = 1'b0;
                continue;
            end
            if (expectDrop) begin
                expectDrop = 1'b0;
                checkOutput("req_drop", mem_req, 1'b0);
                if (mem_req) continue;
            end
            if (mem_req) begin
                if (!active) begin
                    if (reqQ.size() == 0) begin
                        reportFail("unexpected_req", mem_req, 1'b0);
                        continue;
                    end
                    cur       = reqQ.pop_front();
                    active    = 1'b1;
                    reqCycles = 0;
                end
                checkOutput("mem_addr", mem_addr, cur.addr);
                checkOutput("mem_we", mem_we, cur.we);
                if (cur.we) checkOutput("mem_wdata", mem_wdata, cur.wdata);
                reqCycles++;
                if (cur.delay < TIMEOUT && reqCycles == cur.delay + 1) begin
                    mem_ready = 1'b1;
                    if (cur.we) devMem[cur.addr] = cur.wdata;
                    else        mem_rdata = devRead(cur.addr);
                    active     = 1'b0;
                    expectDrop = 1'b1;
                end
            end else if (active) begin
                checkOutput("timeout_req_cycles", reqCycles, TIMEOUT);
                active = 1'b0;
            end
        end
    end

    // Output monitor: every non-bubble packet must match the head of the expected queue.
    initial begin
        pkt_t p;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) continue;
            if (instrout != 16'h0) begin
                if (expQ.size() == 0) begin
                    reportFail("unexpected_out", instrout, 16'h0);
                end else begin
                    p = expQ.pop_front();
                    checkOutput("instrout", instrout, p.instr);
                    checkOutput("wb_en", wb_en, p.en);
                    checkOutput("wb_rd", wb_rd, p.rd);
                    if (p.chk) checkOutput("wb_data", wb_data, p.data);
                    if (p.follow) checkOutput("b2b_gap", cyc - lastCyc, 1);
                    if (p.abort) expErr = 1'b1;
                    checkOutput("mem_err", mem_err, expErr);
                    lastCyc = cyc;
                end
            end else begin
                checkOutput("bubble_wb_en", wb_en, 1'b0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset checks, directed scenarios, random traffic, reset during an access.
    initial begin
        logic [15:0] ins;
        logic [15:0] addr;
        int          kind;
        int          r;
        int          delay;
        reset      = 1'b1;
        instrin    = 16'h0;
        alu_result = 16'h0;
        st_data    = 16'h0;
        refMem[16'h0010] = 16'hBEEF;
        devMem[16'h0010] = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_wb_en", wb_en, 1'b0);
        checkOutput("rst_mem_err", mem_err, 1'b0);
        checkOutput("rst_instrout", instrout, 16'h0);
        checkOutput("rst_wb_data", wb_data, 16'h0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
        checkOutput("rst_wb_rd", wb_rd, 3'h0);
        reset = 1'b0;

        applyStimulus(16'h0A00, 16'h0037, 16'h0, 0, 1'b0);
        applyStimulus(16'h2400, 16'h0010, 16'h0, 2, 1'b0);
        applyStimulus(16'h3200, 16'h0020, 16'h1234, 0, 1'b0);
        applyStimulus(16'h2600, 16'h0020, 16'h0, 0, 1'b0);
        applyStimulus(16'h1A00, 16'h4444, 16'h0, 0, 1'b1);
        applyStimulus(16'h8E00, 16'h0001, 16'h0, 0, 1'b0);
        applyStimulus(16'h2C00, 16'h0010, 16'h0, TIMEOUT - 1, 1'b0);
        applyStimulus(16'h2800, 16'h0030, 16'h0, 99, 1'b0);
        applyStimulus(16'h0200, 16'h1111, 16'h0, 0, 1'b0);
        applyStimulus(16'h3E00, 16'h0031, 16'h7777, TIMEOUT, 1'b0);
        applyStimulus(16'h2A00, 16'h0031, 16'h0, 1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            kind  = $urandom_range(0, 9);
            ins   = randInstr(kind);
            addr  = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) addr = addr | 16'hFFF0;
            r     = $urandom_range(0, 39);
            if (r < 34)       delay = r % 5;
            else if (r == 34) delay = TIMEOUT - 2;
            else if (r == 35) delay = TIMEOUT - 1;
            else if (r == 36) delay = TIMEOUT;
            else              delay = 30;
            if (ins[15:12] == OP_LD || ins[15:12] == OP_ST)
                applyStimulus(ins, addr, 16'($urandom), delay, 1'b0);
            else
                applyStimulus(ins, 16'($urandom), 16'($urandom), 0, 1'b0);
        end
        idleInputs();
        drain();
        checkOutput("mem_err_sticky", mem_err, expErr);

        @(posedge clk);
        #1;
        instrin    = 16'h2400;
        alu_result = 16'h0040;
        begin
            req_t rq;
            rq.addr  = 16'h0040;
            rq.we    = 1'b0;
            rq.wdata = 16'h0;
            rq.delay = 99;
            reqQ.push_back(rq);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_mem_req", mem_req, 1'b0);
        checkOutput("arst_stall", stall, 1'b0);
        checkOutput("arst_wb_en", wb_en, 1'b0);
        checkOutput("arst_instrout", instrout, 16'h0);
        instrin    = 16'h0;
        alu_result = 16'h0;
        reqQ.delete();
        expErr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_mem_req", mem_req, 1'b0);
        checkOutput("post_rst_mem_err", mem_err, 1'b0);
        applyStimulus(16'h0600, 16'h5A5A, 16'h0, 0, 1'b0);
        idleInputs();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
